// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: hunts for frame_sync, assembles 8 slots into dout.
// Optional even-parity slot 8 enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [3:0] sel,
  output logic       locked,
  output logic       sync_err,
  output logic       parity_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [3:0] LAST_SLOT = 4'd8;
`else
  localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       sync_err_q, sync_err_d;
  logic       parity_err_q, parity_err_d;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    parity_err_d = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d = {7'b0, din};
            sel_d    = 4'd1;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          if (sel_q == '0) begin
            if (frame_sync) begin
              shadow_d = {7'b0, din};
              sel_d    = 4'd1;
            end else begin
              sync_err_d = 1'b1;
              state_d    = HUNT;
            end
          end else if (frame_sync) begin
            // Early sync restarts the frame in place; the bit becomes slot 0.
            sync_err_d = 1'b1;
            shadow_d   = {7'b0, din};
            sel_d      = 4'd1;
          end else if (sel_q == LAST_SLOT) begin
            sel_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
            if (^{din, shadow_q} == 1'b0) begin
              dout_d       = shadow_q;
              dout_valid_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
`else
            dout_d       = {din, shadow_q[6:0]};
            dout_valid_d = 1'b1;
`endif
          end else begin
            shadow_d[sel_q[2:0]] = din;
            sel_d                = sel_q + 4'd1;
          end
        end
        default: begin
          state_d = HUNT;
          sel_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      sel_q        <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sel        = sel_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: fixed vector table, directed corner sequences,
// and randomized traffic compared against a queue-based frame model.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] sel;
  logic       locked;
  logic       sync_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  tdm_demux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  // Reference model: bits collected since the last slot-0 sync.
  bit       m_locked;
  bit       m_q[$];
  bit [7:0] m_dout;
  bit       m_valid, m_serr, m_perr;

  task automatic model_reset();
    m_locked = 0; m_q.delete(); m_dout = 8'h00;
    m_valid = 0; m_serr = 0; m_perr = 0;
  endtask

  task automatic model_step(input bit d, input bit f);
    bit [7:0] b;
    bit p;
    m_valid = 0; m_serr = 0; m_perr = 0;
    if (!m_locked) begin
      if (f) begin m_q.delete(); m_q.push_back(d); m_locked = 1; end
    end else if (m_q.size() == 0) begin
      if (f) m_q.push_back(d);
      else begin m_serr = 1; m_locked = 0; end
    end else if (f) begin
      m_serr = 1; m_q.delete(); m_q.push_back(d);
    end else begin
      m_q.push_back(d);
      if (m_q.size() == FRAME_LEN) begin
        p = 0;
        for (int i = 0; i < FRAME_LEN; i++) p ^= m_q[i];
        for (int i = 0; i < 8; i++) b[i] = m_q[i];
        if (FRAME_LEN == 8 || p == 0) begin m_dout = b; m_valid = 1; end
        else m_perr = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".dout"}, dout, m_dout);
    check({tag, ".dout_valid"}, dout_valid, m_valid);
    check({tag, ".sync_err"}, sync_err, m_serr);
    check({tag, ".parity_err"}, parity_err, m_perr);
    check({tag, ".locked"}, locked, m_locked);
    check({tag, ".sel"}, sel, 4'(m_q.size()));
  endtask

  task automatic step(input bit v, input bit d, input bit f, input string tag);
    din_valid = v; din = d; frame_sync = f;
    @(posedge clk);
    if (v) model_step(d, f);
    else begin m_valid = 0; m_serr = 0; m_perr = 0; end
    #1;
    compare_model(tag);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit stall, input string tag);
    bit p;
    p = ^b;
    for (int k = 0; k < 8; k++) begin
      step(1, b[k], k == 0, tag);
      if (stall) step(0, 1'($urandom), 1'($urandom), {tag, ".stall"});
    end
`ifdef TDM_DEMUX_PARITY_EN
    step(1, p, 0, {tag, ".par"});
`else
    if (p) ; // parity slot only exists in the parity build
`endif
  endtask

  typedef struct {
    bit       v, d, f;
    bit [7:0] e_dout;
    bit       e_dv, e_se, e_lk;
    bit [3:0] e_sel;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, d, f, input bit [7:0] e_dout,
                     input bit e_dv, e_se, e_lk, input bit [3:0] e_sel);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.e_dout = e_dout;
    r.e_dv = e_dv; r.e_se = e_se; r.e_lk = e_lk; r.e_sel = e_sel;
    tbl.push_back(r);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifndef TDM_DEMUX_PARITY_EN
    // Acquisition of 8'hA5 (LSB first) after three unsynced bits, then missing sync.
    add(1,1,0, 8'h00, 0,0,0, 4'd0);
    add(1,0,0, 8'h00, 0,0,0, 4'd0);
    add(1,1,0, 8'h00, 0,0,0, 4'd0);
    add(1,1,1, 8'h00, 0,0,1, 4'd1);
    add(1,0,0, 8'h00, 0,0,1, 4'd2);
    add(1,1,0, 8'h00, 0,0,1, 4'd3);
    add(1,0,0, 8'h00, 0,0,1, 4'd4);
    add(1,0,0, 8'h00, 0,0,1, 4'd5);
    add(1,1,0, 8'h00, 0,0,1, 4'd6);
    add(1,0,0, 8'h00, 0,0,1, 4'd7);
    add(1,1,0, 8'hA5, 1,0,1, 4'd0);
    add(0,0,1, 8'hA5, 0,0,1, 4'd0);
    add(1,0,0, 8'hA5, 0,1,0, 4'd0);
    add(1,1,0, 8'hA5, 0,0,0, 4'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].f, "tbl_model");
      check($sformatf("tbl[%0d].dout", i), dout, tbl[i].e_dout);
      check($sformatf("tbl[%0d].dout_valid", i), dout_valid, tbl[i].e_dv);
      check($sformatf("tbl[%0d].sync_err", i), sync_err, tbl[i].e_se);
      check($sformatf("tbl[%0d].locked", i), locked, tbl[i].e_lk);
      check($sformatf("tbl[%0d].sel", i), sel, tbl[i].e_sel);
      check($sformatf("tbl[%0d].parity_err", i), parity_err, 0);
    end
`endif

    // Stalled frame then back-to-back frame.
    send_frame(8'hA5, 1, "stall_a5");
    check("stall_a5.dout", dout, 8'hA5);
    send_frame(8'h3C, 0, "b2b_3c");
    check("b2b_3c.dout", dout, 8'h3C);

    // Early frame_sync at sel=4: restart, then complete an all-ones frame.
    step(1, 0, 1, "early");
    for (int k = 1; k < 4; k++) step(1, 0, 0, "early");
    check("early.sel4", sel, 4'd4);
    step(1, 1, 1, "early.sync");
    check("early.sync_err", sync_err, 1);
    check("early.locked", locked, 1);
    check("early.dout_held", dout, 8'h3C);
    for (int k = 1; k < 8; k++) step(1, 1, 0, "early.fill");
`ifdef TDM_DEMUX_PARITY_EN
    step(1, 0, 0, "early.par");
`endif
    check("early.dout_ff", dout, 8'hFF);

    // Missing sync at slot 0 after a completed frame.
    step(1, 0, 0, "missing");
    check("missing.sync_err", sync_err, 1);
    check("missing.locked", locked, 0);
    check("missing.sel", sel, 4'd0);
    check("missing.dout", dout, 8'hFF);

    // Asynchronous reset mid-frame at sel=5.
    step(1, 1, 1, "midrst");
    for (int k = 1; k < 5; k++) step(1, 1, 0, "midrst");
    check("midrst.sel5", sel, 4'd5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_model("midrst.async");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h81, 0, "post_rst");
    check("post_rst.dout", dout, 8'h81);

`ifdef TDM_DEMUX_PARITY_EN
    // 8'h07 has three ones: parity 1 is even overall, parity 0 is a failure.
    step(1, 1, 1, "par_ok");
    for (int k = 1; k < 8; k++) step(1, k < 3, 0, "par_ok");
    step(1, 1, 0, "par_ok.bit");
    check("par_ok.dout", dout, 8'h07);
    check("par_ok.valid", dout_valid, 1);
    step(1, 1, 1, "par_bad");
    for (int k = 1; k < 8; k++) step(1, k < 3, 0, "par_bad");
    step(1, 0, 0, "par_bad.bit");
    check("par_bad.perr", parity_err, 1);
    check("par_bad.dout", dout, 8'h07);
`endif

    // Randomized traffic with sparse syncs and idle cycles.
    for (int n = 0; n < 4000; n++) begin
      bit v, d, f;
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom);
      f = ($urandom_range(0, 9) == 0) || (m_q.size() == 0 && $urandom_range(0, 1) == 1);
      step(v, d, f, "rand");
      if (dout_valid && sync_err) check("rand.exclusive", 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
